// File: rtl/calib_sequencer.sv
// calib_sequencer
// Top-level sequencer for the LED calibration pass. Walks the LED ID display
// block through every address bit (bit number 0 = address MSB). For each bit
// it strobes the display, waits for a fully valid frame of that bit, lets the
// camera settle, requests one capture and waits for the decode to finish.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle pulse, begins a pass (IDLE only)
//   abort                    level, forces IDLE on the next edge
//   update_address_bit_num   one-cycle strobe loading address_bit_num_req
//   address_bit_num_req      bit number requested from the display block
//   current_address_bit_num  bit number the display block is showing
//   displayed_frame_valid    LED string fully shows the current bit
//   capture_req/ready        capture request handshake (req held until ready)
//   capture_bit_num          tag for the capture request
//   capture_done             one-cycle pulse, accepted capture decoded
//   busy                     high in every state except IDLE
//   done                     one-cycle pulse at the end of a complete pass
//   error                    sticky timeout flag
module calib_sequencer #(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = $clog2(NUM_LEDS),
  parameter int BIT_NUM_WIDTH     = $clog2($clog2(NUM_LEDS)),
  parameter int SETTLE_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES    = 2**24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     update_address_bit_num,
  output logic [BIT_NUM_WIDTH-1:0] address_bit_num_req,
  input  logic [BIT_NUM_WIDTH-1:0] current_address_bit_num,
  input  logic                     displayed_frame_valid,
  output logic                     capture_req,
  input  logic                     capture_ready,
  output logic [BIT_NUM_WIDTH-1:0] capture_bit_num,
  input  logic                     capture_done,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SETTLE_W-1:0]      SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0]     TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_NUM_WIDTH-1:0] BIT_LAST     = BIT_NUM_WIDTH'(LED_ADDRESS_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SET_BIT,
    WAIT_FRAME,
    SETTLE,
    CAPTURE,
    WAIT_DONE,
    NEXT
  } state_t;

  state_t                   state_reg, state_next;
  logic [BIT_NUM_WIDTH-1:0] bit_idx_reg, bit_idx_next;
  logic [SETTLE_W-1:0]      settle_cnt_reg, settle_cnt_next;
  logic [TIMEOUT_W-1:0]     timeout_cnt_reg, timeout_cnt_next;
  logic                     error_reg, error_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      bit_idx_reg     <= '0;
      settle_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_idx_reg     <= bit_idx_next;
      settle_cnt_reg  <= settle_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      error_reg       <= error_next;
    end
  end

  always_comb begin
    state_next             = state_reg;
    bit_idx_next           = bit_idx_reg;
    settle_cnt_next        = settle_cnt_reg;
    timeout_cnt_next       = timeout_cnt_reg;
    error_next             = error_reg;
    update_address_bit_num = 1'b0;
    capture_req            = 1'b0;
    done                   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          error_next   = 1'b0;
          bit_idx_next = '0;
          state_next   = SET_BIT;
        end
      end
      SET_BIT: begin
        update_address_bit_num = 1'b1;
        timeout_cnt_next       = '0;
        state_next             = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        // The display reloads on the strobe edge, so a frame still valid from
        // the previous bit carries the old bit number and cannot match here.
        if (displayed_frame_valid && (current_address_bit_num == bit_idx_reg)) begin
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
      end
      SETTLE: begin
        // Losing the frame restarts the wait; the timeout keeps running so a
        // flickering display still ends in an error eventually.
        if (!displayed_frame_valid) begin
          state_next = WAIT_FRAME;
        end else if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = CAPTURE;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end
      CAPTURE: begin
        capture_req = 1'b1;
        if (capture_ready) begin
          timeout_cnt_next = '0;
          state_next       = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (capture_done) begin
          state_next = NEXT;
        end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
      end
      NEXT: begin
        if (bit_idx_reg == BIT_LAST) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          bit_idx_next = bit_idx_reg + 1'b1;
          state_next   = SET_BIT;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides every transition: registers other than the state hold,
    // so error survives and no done pulse escapes.
    if (abort) begin
      state_next       = IDLE;
      bit_idx_next     = bit_idx_reg;
      settle_cnt_next  = settle_cnt_reg;
      timeout_cnt_next = timeout_cnt_reg;
      error_next       = error_reg;
      done             = 1'b0;
    end
  end

  assign address_bit_num_req = bit_idx_reg;
  assign capture_bit_num     = bit_idx_reg;
  assign busy                = (state_reg != IDLE);
  assign error               = error_reg;

endmodule

// File: tb/tb_calib_sequencer.sv
// tb_calib_sequencer
// Scoreboard bench for calib_sequencer: the stimulus process pushes expected
// strobe bit numbers, capture tags and done pulses; a monitor process pops and
// compares them whenever the DUT presents a strobe, handshake or done.
// Includes a display model (frame valid 3 cycles after each strobe) and a
// capture pipeline model with programmable backpressure and done latency.
module tb_calib_sequencer;

  localparam int AW = 6;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          update_address_bit_num;
  logic [BW-1:0] address_bit_num_req;
  logic [BW-1:0] current_address_bit_num;
  logic          displayed_frame_valid;
  logic          capture_req;
  logic          capture_ready = 1'b0;
  logic [BW-1:0] capture_bit_num;
  logic          capture_done = 1'b0;
  logic          busy;
  logic          done;
  logic          error;

  calib_sequencer #(
    .NUM_LEDS      (50),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .abort                  (abort),
    .update_address_bit_num (update_address_bit_num),
    .address_bit_num_req    (address_bit_num_req),
    .current_address_bit_num(current_address_bit_num),
    .displayed_frame_valid  (displayed_frame_valid),
    .capture_req            (capture_req),
    .capture_ready          (capture_ready),
    .capture_bit_num        (capture_bit_num),
    .capture_done           (capture_done),
    .busy                   (busy),
    .done                   (done),
    .error                  (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int exp_strobe[$];
  int exp_cap[$];
  int exp_done  = 0;
  int done_seen = 0;
  int hs_count  = 0;
  int req_len   = 0;
  int bp_cycles = 0;
  int done_lat  = 3;
  logic disp_en     = 1'b1;
  logic frame_block = 1'b0;
  logic outstanding = 1'b0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Display model: reloads on the strobe edge, frame valid 3 cycles later.
  logic [BW-1:0] disp_bit = '0;
  int            disp_dly = 0;
  always @(posedge clk) begin
    if (rst) begin
      disp_bit <= '0;
      disp_dly <= 0;
    end else if (update_address_bit_num) begin
      disp_bit <= address_bit_num_req;
      disp_dly <= 1;
    end else if (disp_dly != 0 && disp_dly < 3) begin
      disp_dly <= disp_dly + 1;
    end
  end
  assign current_address_bit_num = disp_bit;
  assign displayed_frame_valid    = disp_en && !frame_block && (disp_dly == 3);

  // Capture pipeline model, updated 2 time units after each falling edge.
  initial begin
    int bp;
    int dt;
    logic hs_prev;
    bp = 0;
    dt = -1;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      capture_done = 1'b0;
      if (dt == 0) begin
        capture_done = 1'b1;
        outstanding  = 1'b0;
        dt = -1;
      end else if (dt > 0) begin
        dt--;
      end
      if (hs_prev) begin
        capture_ready = 1'b0;
        outstanding   = 1'b1;
        dt = done_lat;
        bp = 0;
      end
      if (capture_req && !capture_ready) begin
        if (bp >= bp_cycles) capture_ready = 1'b1;
        else bp++;
      end
      hs_prev = capture_req && capture_ready;
    end
  end

  // Monitor: samples after all drivers have settled, well before the next rising edge.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (update_address_bit_num) begin
          $display("strobe  bit=%0d cycle=%0d", address_bit_num_req, cyc);
          if (exp_strobe.size() == 0) check("strobe_unexpected", int'(address_bit_num_req), -1);
          else begin
            e = exp_strobe.pop_front();
            check("strobe_bit", int'(address_bit_num_req), e);
          end
        end
        if (capture_req) begin
          req_len++;
          check("no_overlap", int'(outstanding), 0);
          if (exp_cap.size() == 0) check("capture_unexpected", int'(capture_bit_num), -1);
          else check("capture_tag", int'(capture_bit_num), exp_cap[0]);
          if (capture_ready) begin
            $display("capture tag=%0d req_cycles=%0d cycle=%0d", capture_bit_num, req_len, cyc);
            check("req_len", req_len, bp_cycles + 1);
            if (exp_cap.size() > 0) void'(exp_cap.pop_front());
            hs_count++;
            req_len = 0;
          end
        end
        if (done) begin
          done_seen++;
          $display("done    cycle=%0d", cyc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pass();
    for (int i = 0; i < AW; i++) begin
      exp_strobe.push_back(i);
      exp_cap.push_back(i);
    end
    exp_done++;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int t);
    bit got = 0;
    t = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (displayed_frame_valid) begin got = 1; t = cyc; break; end
    end
    check("valid_seen", int'(got), 1);
  endtask

  task automatic wait_capture(output int t);
    bit got = 0;
    t = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (capture_req) begin got = 1; t = cyc; break; end
    end
    check("capture_seen", int'(got), 1);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (done) begin got = 1; break; end
    end
    check("done_in_time", int'(got), 1);
    if (got) begin
      tick();
      check("busy_after_done", int'(busy), 0);
    end
    check("error_after_pass", int'(error), 0);
    check("done_count", done_seen, exp_done);
    check("strobes_left", exp_strobe.size(), 0);
    check("captures_left", exp_cap.size(), 0);
  endtask

  initial begin
    int t0;
    int t1;
    int hs_base;
    bit got;

    // Reset state
    repeat (3) tick();
    check("rst_update", int'(update_address_bit_num), 0);
    check("rst_req", int'(address_bit_num_req), 0);
    check("rst_capture_req", int'(capture_req), 0);
    check("rst_capture_tag", int'(capture_bit_num), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    rst = 1'b0;
    tick();

    // Nominal pass: valid -> capture request after 4 settle cycles
    start_pass();
    check("busy_after_start", int'(busy), 1);
    wait_valid(t0);
    wait_capture(t1);
    check("settle_latency", t1 - t0, 5);
    wait_done();

    // Capture backpressure: ready held low for 10 cycles on every bit
    bp_cycles = 10;
    start_pass();
    wait_done();
    bp_cycles = 0;

    // Frame drop at settle count 2 on bit 0
    start_pass();
    wait_valid(t0);
    repeat (3) tick();
    frame_block = 1'b1;
    repeat (3) tick();
    frame_block = 1'b0;
    t0 = cyc;
    wait_capture(t1);
    check("resettle_latency", t1 - t0, 5);
    wait_done();

    // Timeout in WAIT_FRAME, then a normal pass clears error
    disp_en = 1'b0;
    exp_strobe.push_back(0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    got = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (!busy) begin got = 1; break; end
    end
    check("timeout_reached", int'(got), 1);
    check("timeout_cycles", cyc - t0, 65);
    check("timeout_error", int'(error), 1);
    check("timeout_no_done", done_seen, exp_done);
    check("timeout_strobes_left", exp_strobe.size(), 0);
    disp_en = 1'b1;
    start_pass();
    check("error_cleared", int'(error), 0);
    wait_done();

    // Abort in WAIT_DONE at bit 3; the late capture_done must be ignored
    done_lat = 8;
    hs_base = hs_count;
    start_pass();
    got = 0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (hs_count - hs_base >= 4) begin got = 1; break; end
    end
    check("bit3_handshake", int'(got), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_error", int'(error), 0);
    repeat (20) tick();
    check("abort_idle_after_done", int'(busy), 0);
    check("abort_strobes_left", exp_strobe.size(), 2);
    check("abort_captures_left", exp_cap.size(), 2);
    check("abort_no_done", done_seen, exp_done - 1);
    exp_strobe.delete();
    exp_cap.delete();
    exp_done--;
    done_lat = 3;
    start_pass();
    wait_done();

    // Start while busy is ignored
    start_pass();
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();

    // Start together with abort in IDLE stays IDLE
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    repeat (5) tick();
    check("start_abort_still_idle", int'(busy), 0);
    check("start_abort_no_done", done_seen, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
